pipe_stage_buf: RTL

- Parametrised successor to the fixed IF/ID/EX stage registers in the CPU.
- A DEPTH-entry elastic pipeline buffer carrying one DATA_W-bit payload. The payload is the concatenated control bits, pc, inst and operands.
- Has a valid/ready handshake on both sides, plus a hold input (stall), a flush input (branch/ecall clear) and a programmable bubble value.
- Sits between any two pipeline stages. With DEPTH>=2 it sustains one transfer per cycle without a combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_stats.sv | 62 ++++++
 rtl/pipe_stage_buf.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the elastic pipeline stage buffer.
//
//   NOP_INST : RISC-V canonical NOP (addi x0,x0,0), the default bubble value.
//   ptr_t    : storage pointer type, wide enough for the largest supported
//              DEPTH (4 entries -> 2 bits).
//   cnt_w()  : width of an occupancy counter able to hold 0..depth.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam logic [31:0] NOP_INST  = 32'h00000013;
   localparam int          MAX_DEPTH = 4;
   localparam int          PTR_W     = 2;

   typedef logic [PTR_W-1:0] ptr_t;

   // Occupancy ranges over 0..depth inclusive, hence depth+1 states.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage_stats.sv
// -----------------------------------------------------------------------------
// pipe_stage_stats
//   Saturating event counters observing a pipe_stage_buf. Only instantiated
//   when PIPE_STAGE_BUF_STATS_EN is defined.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset, clears both counters
//   flush          in   buffer flush request this cycle
//   stall          in   buffer hold request this cycle
//   count          in   buffer occupancy before this cycle's update
//   stat_flushed   out  total entries discarded by flushes (saturating)
//   stat_stall_cyc out  cycles spent stalled with data held (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_stats #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             stall,
   input  logic [CNT_W-1:0] count,
   output logic [15:0]      stat_flushed,
   output logic [15:0]      stat_stall_cyc
);

   localparam logic [15:0] SAT = 16'hFFFF;

   logic [15:0] flushed_reg, flushed_next;
   logic [15:0] stall_cyc_reg, stall_cyc_next;
   logic [16:0] flushed_sum;

   always_comb begin
      flushed_next   = flushed_reg;
      stall_cyc_next = stall_cyc_reg;
      // One spare bit catches the carry so the add can clamp instead of wrap.
      flushed_sum    = {1'b0, flushed_reg} + 17'(count);

      if (flush) begin
         flushed_next = flushed_sum[16] ? SAT : flushed_sum[15:0];
      end

      // A stall only costs throughput when something is actually held.
      if (stall && (count != '0) && (stall_cyc_reg != SAT)) begin
         stall_cyc_next = stall_cyc_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flushed_reg   <= '0;
         stall_cyc_reg <= '0;
      end else begin
         flushed_reg   <= flushed_next;
         stall_cyc_reg <= stall_cyc_next;
      end
   end

   assign stat_flushed   = flushed_reg;
   assign stat_stall_cyc = stall_cyc_reg;

endmodule : pipe_stage_stats

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//   DEPTH-entry elastic buffer placed between two CPU pipeline stages. Carries
//   one DATA_W-bit payload (control bits, pc, inst, operands concatenated).
//   DEPTH=1 behaves as a plain stage register at half throughput; DEPTH>=2
//   gives full throughput with no combinational ready path between stages.
//
// Parameters:
//   DATA_W  payload width (1..256)
//   DEPTH   storage entries (1..4)
//   BUBBLE  value shown on out_data while out_valid=0 (zero-extended or
//           truncated to DATA_W)
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   upstream offers in_data
//   in_ready   out  buffer has a free entry (registered state only)
//   in_data    in   payload
//   stall      in   hold: nothing leaves the buffer this cycle
//   flush      in   drop all held entries and any push this cycle
//   out_valid  out  head entry presented (count>0 && !stall)
//   out_ready  in   downstream accepts
//   out_data   out  head entry when out_valid, else BUBBLE
//   count      out  current occupancy
//
// Build option:
//   PIPE_STAGE_BUF_STATS_EN adds stat_flushed / stat_stall_cyc outputs fed by
//   pipe_stage_stats. Handshake behaviour is identical in both builds.
// -----------------------------------------------------------------------------
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int          DATA_W = 32,
   parameter int          DEPTH  = 2,
   parameter logic [31:0] BUBBLE = NOP_INST
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      stall,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [cnt_w(DEPTH)-1:0]   count
`ifdef PIPE_STAGE_BUF_STATS_EN
   ,
   output logic [15:0]               stat_flushed,
   output logic [15:0]               stat_stall_cyc
`endif
);

   localparam int                CNT_W    = cnt_w(DEPTH);
   localparam logic [DATA_W-1:0] BUBBLE_W = DATA_W'(BUBBLE);
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
   localparam ptr_t              LAST_PTR = ptr_t'(DEPTH - 1);

   // Wrap explicitly at DEPTH rather than relying on pointer overflow, so
   // non-power-of-two depths (DEPTH=3: 2 -> 0) work.
   function automatic ptr_t ptr_adv(input ptr_t p);
      return (p == LAST_PTR) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
   endfunction

   logic [CNT_W-1:0] count_reg, count_next;
   ptr_t             rd_ptr_reg, rd_ptr_next;
   ptr_t             wr_ptr_reg, wr_ptr_next;

   logic             push;
   logic             pop;
   logic             not_empty;
   logic [DATA_W-1:0] head_data;

   // Each entry contributes its data to the read OR-tree only when selected,
   // so the head mux never indexes with a pointer wider than the array.
   wire [DEPTH-1:0][DATA_W-1:0] head_terms;

   // ---------------------------------------------------------------------
   // Handshake: ready/valid come from registered occupancy only (plus the
   // stall gate on the output side), never from the opposite handshake.
   // ---------------------------------------------------------------------
   assign not_empty = (count_reg != '0);
   assign in_ready  = (count_reg < DEPTH_C);
   assign out_valid = not_empty && !stall;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready;

   // ---------------------------------------------------------------------
   // Storage: small register file, one write port, combinational head read.
   // Contents are deliberately not reset; occupancy alone says what is live.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] data_reg;

      always_ff @(posedge clk) begin
         if (push && (wr_ptr_reg == ptr_t'(gi))) begin
            data_reg <= in_data;
         end
      end

      assign head_terms[gi] = (rd_ptr_reg == ptr_t'(gi)) ? data_reg : '0;
   end

   always_comb begin
      head_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         head_data = head_data | head_terms[i];
      end
   end

   assign out_data = out_valid ? head_data : BUBBLE_W;

   // ---------------------------------------------------------------------
   // Pointer / occupancy update. Flush wins over push, pop and stall.
   // ---------------------------------------------------------------------
   always_comb begin
      count_next  = count_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;

      if (flush) begin
         count_next  = '0;
         rd_ptr_next = '0;
         wr_ptr_next = '0;
      end else begin
         if (push) begin
            wr_ptr_next = ptr_adv(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_next = ptr_adv(rd_ptr_reg);
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
      end else begin
         count_reg  <= count_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
      end
   end

   assign count = count_reg;

`ifdef PIPE_STAGE_BUF_STATS_EN
   pipe_stage_stats #(
      .CNT_W (CNT_W)
   ) u_stats (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .stall          (stall),
      .count          (count_reg),
      .stat_flushed   (stat_flushed),
      .stat_stall_cyc (stat_stall_cyc)
   );
`endif

endmodule : pipe_stage_buf
